// File: rtl/timer_bus_if.sv
// Peripheral bus bundle shared by the MIPS timer block: chip select, strobes,
// register offset, write data and registered read data.
interface timer_bus_if;
  logic        CS_N;
  logic        WR_N;
  logic        RD_N;
  logic [11:0] Addr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;

  modport master (
    output CS_N, WR_N, RD_N, Addr, DataIn,
    input  DataOut
  );

  modport slave (
    input  CS_N, WR_N, RD_N, Addr, DataIn,
    output DataOut
  );
endinterface

// File: rtl/timer_count_compare.sv
// Prescaled 32-bit count/compare timer with periodic and one-shot modes.
// Optional input capture is built only when TIMER_CAPTURE_EN is defined.
//
// state   | meaning
// STOPPED | counter frozen, prescaler held at 0
// RUNNING | prescaler ticking, COUNT advancing on each tick
// EXPIRED | one-shot match reached; COUNT held, CTRL.EN cleared
module timer_count_compare (
  input  logic        clk,
  input  logic        reset,
  timer_bus_if.slave  bus,
  input  logic [31:0] CompareR,
  input  logic        cap_in,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUNNING = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] count_q, count_d;
  logic [7:0]  presc_cnt_q, presc_cnt_d;
  logic        ctrl_en_q, ctrl_periodic_q, ctrl_ie_q;
  logic [7:0]  ctrl_presc_q;
  logic        match_q;
  logic        match_set;
  logic        cap_flag_q;
  logic [31:0] capture_q;
  logic [31:0] rd_data;

  logic wr_en, rd_en;
  logic wr_count, wr_ctrl, wr_status;
  logic tick;
  logic expire;

  assign wr_en     = ~bus.CS_N & ~bus.WR_N;
  assign rd_en     = ~bus.CS_N & ~bus.RD_N;
  assign wr_count  = wr_en && (bus.Addr == 12'h004);
  assign wr_ctrl   = wr_en && (bus.Addr == 12'h008);
  assign wr_status = wr_en && (bus.Addr == 12'h00C);

  assign tick   = (state_q == RUNNING) && (presc_cnt_q == ctrl_presc_q);
  assign expire = tick && (count_q == CompareR) && !ctrl_periodic_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= STOPPED;
      count_q     <= '0;
      presc_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      presc_cnt_q <= presc_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    presc_cnt_d = presc_cnt_q;
    match_set   = 1'b0;

    if (tick) begin
      presc_cnt_d = '0;
      if (count_q == CompareR) begin
        match_set = 1'b1;
        if (ctrl_periodic_q) count_d = '0;
        else                 state_d = EXPIRED;
      end else begin
        count_d = count_q + 32'd1;
      end
    end else if (state_q == RUNNING) begin
      presc_cnt_d = presc_cnt_q + 8'd1;
    end

    // A CTRL write overrides a same-cycle one-shot expiry.
    case (state_q)
      STOPPED: if (wr_ctrl && bus.DataIn[0]) state_d = RUNNING;
      RUNNING: if (wr_ctrl) state_d = bus.DataIn[0] ? RUNNING : STOPPED;
      EXPIRED: begin
        if (wr_ctrl) begin
          state_d = bus.DataIn[0] ? RUNNING : STOPPED;
          if (bus.DataIn[0]) count_d = '0;
        end
      end
      default: state_d = STOPPED;
    endcase

    if (wr_count) begin
      count_d     = bus.DataIn;
      presc_cnt_d = '0;
    end
    if (wr_ctrl && (bus.DataIn[15:8] != ctrl_presc_q)) presc_cnt_d = '0;
    if (state_d != RUNNING) presc_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en_q       <= 1'b0;
      ctrl_periodic_q <= 1'b0;
      ctrl_ie_q       <= 1'b0;
      ctrl_presc_q    <= '0;
      match_q         <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en_q       <= bus.DataIn[0];
        ctrl_periodic_q <= bus.DataIn[1];
        ctrl_ie_q       <= bus.DataIn[2];
        ctrl_presc_q    <= bus.DataIn[15:8];
      end else if (expire) begin
        ctrl_en_q <= 1'b0;
      end
      // A new match beats a same-cycle write-1-to-clear.
      match_q <= match_set | (match_q & ~(wr_status & bus.DataIn[0]));
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic cap_sync1_q, cap_sync2_q, cap_dly_q;
  logic cap_rise;

  assign cap_rise = cap_sync2_q & ~cap_dly_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_sync1_q <= 1'b0;
      cap_sync2_q <= 1'b0;
      cap_dly_q   <= 1'b0;
      capture_q   <= '0;
      cap_flag_q  <= 1'b0;
    end else begin
      cap_sync1_q <= cap_in;
      cap_sync2_q <= cap_sync1_q;
      cap_dly_q   <= cap_sync2_q;
      if (cap_rise) capture_q <= count_q;
      cap_flag_q <= cap_rise | (cap_flag_q & ~(wr_status & bus.DataIn[1]));
    end
  end

  assign IRQ = (match_q | cap_flag_q) & ctrl_ie_q;
`else
  logic unused_cap_in;
  assign unused_cap_in = cap_in;
  assign capture_q     = '0;
  assign cap_flag_q    = 1'b0;
  assign IRQ           = match_q & ctrl_ie_q;
`endif

  always_comb begin
    rd_data = '0;
    case (bus.Addr)
      12'h000: rd_data = CompareR;
      12'h004: rd_data = count_q;
      12'h008: rd_data = {16'h0000, ctrl_presc_q, 5'b00000,
                          ctrl_ie_q, ctrl_periodic_q, ctrl_en_q};
      12'h00C: rd_data = {30'd0, cap_flag_q, match_q};
      12'h010: rd_data = capture_q;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)      bus.DataOut <= '0;
    else if (rd_en) bus.DataOut <= rd_data;
  end

endmodule

// File: tb/tb_timer_count_compare.sv
// Directed bench for timer_count_compare; bus ops are driven and sampled on
// the falling edge so each op occupies exactly one clk.
module tb_timer_count_compare;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] CompareR;
  logic        cap_in;
  logic        IRQ;
  int          total = 0;
  int          bad   = 0;

  timer_bus_if bus ();

  timer_count_compare dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .CompareR (CompareR),
    .cap_in   (cap_in),
    .IRQ      (IRQ)
  );

  always #5 clk = ~clk;

  task automatic bus_idle();
    bus.CS_N   = 1'b1;
    bus.WR_N   = 1'b1;
    bus.RD_N   = 1'b1;
    bus.Addr   = '0;
    bus.DataIn = '0;
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
    bus.CS_N = 1'b0; bus.WR_N = 1'b0; bus.Addr = a; bus.DataIn = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
    bus.CS_N = 1'b0; bus.RD_N = 1'b0; bus.Addr = a;
    @(negedge clk);
    bus_idle();
    d = bus.DataOut;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus_idle();
    cap_in = 1'b0;
    idle(3);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    CompareR = 32'hFFFF_FFFF;
    apply_reset();
    total++; if (bus.DataOut !== 32'h0) begin bad++; $display("FAIL reset_dataout got=%h exp=%h", bus.DataOut, 32'h0); end
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", IRQ); end
    bus_read(12'h000, d);
    total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_compare got=%h exp=ffffffff", d); end
    bus_read(12'h004, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_count got=%h exp=0", d); end
    bus_read(12'h008, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_ctrl got=%h exp=0", d); end
    bus_read(12'h00C, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_status got=%h exp=0", d); end
    bus_read(12'h020, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped_read got=%h exp=0", d); end
  endtask

  task automatic test_periodic();
    logic [31:0] d;
    CompareR = 32'd4;
    apply_reset();
    bus_write(12'h008, 32'h0000_0007);
    for (int i = 0; i < 5; i++) begin
      bus_read(12'h004, d);
      total++; if (d !== 32'(i)) begin bad++; $display("FAIL periodic_count[%0d] got=%h exp=%h", i, d, 32'(i)); end
      total++; if (IRQ !== (i == 4)) begin bad++; $display("FAIL periodic_irq[%0d] got=%b exp=%b", i, IRQ, (i == 4)); end
    end
    bus_read(12'h004, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL periodic_reload got=%h exp=0", d); end
    total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL periodic_irq_level got=%b exp=1", IRQ); end
    bus_write(12'h00C, 32'h1);
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL periodic_irq_clear got=%b exp=0", IRQ); end
    bus_read(12'h00C, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL periodic_status_clear got=%h exp=0", d); end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    CompareR = 32'd2;
    apply_reset();
    bus_write(12'h008, 32'h0000_0305);
    idle(11);
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL oneshot_early_irq got=%b exp=0", IRQ); end
    idle(1);
    total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL oneshot_irq_at_12 got=%b exp=1", IRQ); end
    bus_read(12'h008, d);
    total++; if (d !== 32'h0000_0304) begin bad++; $display("FAIL oneshot_ctrl_en_clear got=%h exp=00000304", d); end
    bus_read(12'h004, d);
    total++; if (d !== 32'd2) begin bad++; $display("FAIL oneshot_count_hold got=%h exp=2", d); end
    bus_read(12'h00C, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL oneshot_status got=%h exp=1", d); end
    idle(6);
    bus_read(12'h004, d);
    total++; if (d !== 32'd2) begin bad++; $display("FAIL oneshot_count_still got=%h exp=2", d); end
    bus_write(12'h00C, 32'h1);
    bus_write(12'h008, 32'h0000_0305);
    for (int i = 0; i < 5; i++) begin
      bus_read(12'h004, d);
      total++; if (d !== ((i == 4) ? 32'd1 : 32'd0)) begin bad++; $display("FAIL oneshot_restart[%0d] got=%h exp=%h", i, d, (i == 4) ? 32'd1 : 32'd0); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    CompareR = 32'd5;
    apply_reset();
    bus_write(12'h004, 32'hFFFF_FFFE);
    bus_write(12'h008, 32'h0000_0007);
    bus_read(12'h004, d);
    total++; if (d !== 32'hFFFF_FFFE) begin bad++; $display("FAIL wrap_fe got=%h exp=fffffffe", d); end
    bus_read(12'h004, d);
    total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_ff got=%h exp=ffffffff", d); end
    bus_read(12'h004, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL wrap_zero got=%h exp=0", d); end
    bus_read(12'h00C, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL wrap_no_match got=%h exp=0", d); end
    bus_read(12'h004, d);
    total++; if (d !== 32'd2) begin bad++; $display("FAIL wrap_count2 got=%h exp=2", d); end
    idle(2);
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL wrap_irq_early got=%b exp=0", IRQ); end
    idle(1);
    total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL wrap_irq_match got=%b exp=1", IRQ); end
    bus_read(12'h004, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL wrap_reload got=%h exp=0", d); end
  endtask

  task automatic test_collisions();
    logic [31:0] d;
    CompareR = 32'd3;
    apply_reset();
    bus_write(12'h008, 32'h0000_0007);
    idle(3);
    bus_write(12'h00C, 32'h1);
    total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL set_wins_irq got=%b exp=1", IRQ); end
    bus_read(12'h00C, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL set_wins_status got=%h exp=1", d); end
    bus_write(12'h004, 32'h10);
    bus_read(12'h004, d);
    total++; if (d !== 32'h10) begin bad++; $display("FAIL count_write_wins got=%h exp=10", d); end
    bus_read(12'h004, d);
    total++; if (d !== 32'h11) begin bad++; $display("FAIL count_after_write got=%h exp=11", d); end
  endtask

  task automatic test_capture();
    logic [31:0] d;
    CompareR = 32'd100;
    apply_reset();
    bus_write(12'h008, 32'h0000_0007);
    idle(6);
    cap_in = 1'b1;
    idle(2);
    cap_in = 1'b0;
    idle(1);
    bus_read(12'h010, d);
`ifdef TIMER_CAPTURE_EN
    total++; if (d !== 32'd8) begin bad++; $display("FAIL capture_value got=%h exp=8", d); end
    bus_read(12'h00C, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL capture_status got=%h exp=2", d); end
    total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL capture_irq got=%b exp=1", IRQ); end
`else
    total++; if (d !== 32'h0) begin bad++; $display("FAIL capture_disabled got=%h exp=0", d); end
    bus_read(12'h00C, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL capture_status_disabled got=%h exp=0", d); end
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL capture_irq_disabled got=%b exp=0", IRQ); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    CompareR = 32'd1000;
    apply_reset();
    bus_write(12'h008, 32'h0000_0007);
    idle(5);
    bus_read(12'h004, d);
    total++; if (d !== 32'd5) begin bad++; $display("FAIL mid_count_before got=%h exp=5", d); end
    reset = 1'b1;
    bus.CS_N = 1'b0; bus.WR_N = 1'b0; bus.RD_N = 1'b0;
    bus.Addr = 12'h004; bus.DataIn = 32'h55;
    @(negedge clk);
    bus_idle();
    reset = 1'b0;
    total++; if (bus.DataOut !== 32'h0) begin bad++; $display("FAIL mid_reset_dataout got=%h exp=0", bus.DataOut); end
    bus_read(12'h004, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_reset_count got=%h exp=0", d); end
    bus_read(12'h008, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_reset_ctrl got=%h exp=0", d); end
  endtask

  initial begin
    reset    = 1'b1;
    cap_in   = 1'b0;
    CompareR = 32'hFFFF_FFFF;
    bus_idle();
    @(negedge clk);
    test_reset();
    test_periodic();
    test_oneshot();
    test_wrap();
    test_collisions();
    test_capture();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/timer_count_compare.md
# timer_count_compare

Memory-mapped 32-bit timer that sits directly downstream of the compare register in the MIPS timer peripheral. It consumes the 32-bit compare value and shares the peripheral's chip-select/write bus decode. It runs a prescaled up-counter and raises a match flag and interrupt when the count equals the compare value. It supports periodic and one-shot modes, with a registered bus readback path.

## Interface
- No parameters; all widths fixed.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- CS_N  in  1  peripheral chip select, active low
- WR_N  in  1  write strobe, active low
- RD_N  in  1  read strobe, active low
- Addr  in  12  register offset within peripheral
- DataIn  in  32  write data
- CompareR  in  32  compare value from the compare register (reset value 0xFFFF_FFFF)
- cap_in  in  1  asynchronous capture input; used only when TIMER_CAPTURE_EN is defined
- DataOut  out  32  registered read data
- IRQ  out  1  timer interrupt, active high

## Operation
- Register map:
  - 0x000: read returns CompareR. Writes are owned by the compare register and ignored here.
  - 0x004: COUNT (R/W).
  - 0x008: CTRL (R/W). Bit0 EN; bit1 PERIODIC; bit2 IE; bits[15:8] PRESC. Other bits read 0.
  - 0x00C: STATUS. Bit0 MATCH; bit1 CAP. Write 1 to clear each bit.
  - 0x010: CAPTURE (RO).
  - Unmapped offsets read 0; writes to them are ignored.
- Write decode: ~CS_N & ~WR_N. Read decode: ~CS_N & ~RD_N.
- Prescaler: 8-bit. While RUNNING, tick asserts for one clk every PRESC+1 cycles; PRESC=0 gives a tick every cycle. The prescaler holds at 0 outside RUNNING.
- FSM:
  - STOPPED (reset state) → RUNNING on a CTRL write with EN=1. COUNT is kept.
  - RUNNING → STOPPED on a CTRL write with EN=0.
  - RUNNING → EXPIRED on match when PERIODIC=0. CTRL.EN auto-clears and COUNT holds.
  - EXPIRED → RUNNING on a CTRL write with EN=1. COUNT is cleared to 0.
  - EXPIRED → STOPPED on a CTRL write with EN=0.
- On tick:
  - If COUNT==CompareR: set MATCH. If PERIODIC=1, COUNT←0; otherwise enter EXPIRED.
  - Otherwise COUNT←COUNT+1, modulo 2^32. 0xFFFF_FFFF wraps to 0 with no flag unless it equals CompareR.
- Match period is (CompareR+1)·(PRESC+1) clk cycles.
- IRQ = MATCH & IE, decoded combinationally from registered bits. It is level-sensitive and stays high until MATCH is cleared.

## Timing
- Reset values: COUNT=0, CTRL=0, STATUS=0, CAPTURE=0, DataOut=0, IRQ=0, prescaler=0, state STOPPED.
- A write takes effect at the clk edge on which it is sampled.
- Read latency: DataOut is valid 1 cycle after the read strobe is sampled. It holds its last value when no read is decoded.
- A COUNT write in the same cycle as a tick: the write wins, the increment is lost, and the prescaler restarts at 0.
- A STATUS clear in the same cycle as a new match: set wins, and MATCH stays 1.
- A CTRL write that changes PRESC while RUNNING restarts the prescaler from 0.
- Reset asserted mid-count returns everything to reset values on the next edge, regardless of bus activity.
- Match is evaluated against the CompareR value present on the tick cycle. A CompareR change takes effect immediately.

## Configuration
- TIMER_CAPTURE_EN defined:
  - cap_in is synchronised with 2 flops.
  - A synchronised rising edge latches COUNT into CAPTURE and sets STATUS.CAP. Input-to-capture latency is 3 cycles.
  - IRQ = (MATCH|CAP) & IE.
  - A capture and a COUNT update in the same cycle: CAPTURE takes the pre-update COUNT.
- TIMER_CAPTURE_EN undefined:
  - cap_in is ignored.
  - CAPTURE and STATUS.CAP read 0.
  - IRQ = MATCH & IE.

## Test plan
- Reset, then read 0x000, 0x004, 0x008 and 0x00C → 0xFFFF_FFFF, 0, 0, 0; IRQ=0.
- CompareR=4, CTRL=0x7 (EN, PERIODIC, IE, PRESC=0) → COUNT cycles 0..4. MATCH and IRQ rise on the tick at COUNT=4, then COUNT=0. Clearing with STATUS write 0x1 drops IRQ the next cycle.
- CompareR=2, PRESC=3, PERIODIC=0, EN=1 → match after 12 clk. State is EXPIRED, CTRL.EN reads 0 and COUNT holds 2. A CTRL write of EN=1 restarts from COUNT=0.
- Write COUNT=0xFFFF_FFFE with CompareR=5, run → COUNT wraps to 0 with no MATCH, then matches at 5.
- STATUS clear 0x1 on the exact cycle of a new match → MATCH remains 1. A COUNT write of 0x10 on a tick cycle → COUNT reads 0x10.
- With TIMER_CAPTURE_EN: pulse cap_in while COUNT=7 → CAPTURE=7 or 8 per the 3-cycle latency, and STATUS.CAP=1. Without the macro → CAPTURE reads 0.
